interval_capture: RTL and testbench
===================================

Name: interval_capture

Overview:
- Measures elapsed clock-enable ticks between a start event and a stop event, and presents the result with a valid/ack handshake.
- It is the measuring counterpart of the loadable down counter: the down counter counts a loaded value down to zero, and this block counts up from zero to produce a value.
- The captured value has the same width as the down counter's load/count path, so it can be fed back as a reload value.
- Sits in the tt_um top level between the raw input pins and the obstacle/timer logic.

Parameters:
- WIDTH, 9, counter and captured value width (matches the 9-bit down counter count).
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start_in  input  1  asynchronous start pin, rising-edge sensitive
- stop_in  input  1  asynchronous stop pin, rising-edge sensitive
- tick_en  input  1  synchronous count enable; count advances only on clk edges where this is 1
- clr  input  1  synchronous abort; returns to IDLE
- cap_ack  input  1  consumer accepts the captured value
- count  output  WIDTH  live counter value
- cap_value  output  WIDTH  captured interval
- cap_valid  output  1  cap_value is valid
- overflow  output  1  sticky saturation flag for the current/last measurement
- busy  output  1  high in RUN

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; count, cap_value, cap_valid, overflow, busy all 0.
  - All synchronizer and edge-history flops are 0.
  - Deassertion is taken on the next clk edge.
- Input conditioning:
  - Each of start_in and stop_in passes through SYNC_STAGES flops, then a rising-edge detect (sync & ~prev).
  - Edge detection produces a single-cycle pulse (start_p, stop_p).
  - Latency: with a pin rising before edge k, the FSM acts on edge k+SYNC_STAGES (edge 3 for the default).
  - A pin held high produces exactly one pulse.
- FSM states: IDLE, RUN, HOLD. busy = (state==RUN).
- IDLE:
  - On start_p: count<=0, overflow<=0, go to RUN.
  - stop_p is ignored.
  - If start_p and stop_p arrive in the same cycle, start wins and stop is dropped.
- RUN:
  - With tick_en=1 and count<2^WIDTH-1: count<=count+1.
  - With tick_en=1 and count==2^WIDTH-1: count holds and overflow<=1 (saturate, never wrap).
  - On stop_p: cap_value<=count (the value before any increment in that cycle); count is not incremented that cycle; cap_valid<=1; go to HOLD.
  - start_p is ignored in RUN (no restart).
- HOLD:
  - cap_valid=1 while in HOLD; cap_value and count are frozen.
  - On cap_ack: cap_valid<=0, go to IDLE.
  - start_p and stop_p are ignored in HOLD. A start edge that arrives in HOLD is lost; it is not queued.
- cap_ack outside HOLD: no effect.
- clr, in any state, has priority over every other event:
  - state<=IDLE, count<=0, cap_valid<=0, overflow<=0.
  - cap_value is retained.
- Arithmetic: unsigned, WIDTH bits, saturating only.
- Reset asserted mid-measurement: immediate IDLE and all outputs 0; the measurement is discarded.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, HOLD} with 2-bit encoding.
  - Default count width constant (9), shared with the down counter.
  - Default SYNC_STAGES constant.
- Sub-module: edge_sync (parameter SYNC_STAGES; ports clk, rst_n, d, pulse). Instantiated twice, once for start and once for stop.
- The FSM and counter live in interval_capture.

Test Plan:
- Basic capture: tick_en=1; pulse start_in; 5 cycles after the FSM enters RUN, pulse stop_in → cap_value=5+SYNC_STAGES (pin-to-action latency included), cap_valid=1, overflow=0; cap_ack → cap_valid=0, state IDLE next cycle.
- Gated ticks: tick_en toggling 1,0,1,0 for 20 cycles in RUN → cap_value=10; count frozen on tick_en=0 cycles.
- Saturation: tick_en=1, 600 cycles in RUN → count sticks at 511, overflow=1; stop → cap_value=511.
- Ignored events:
  - start_in pulsed again in RUN → count is not reset.
  - stop_in in IDLE → no transition.
  - start_in held high for 50 cycles → one measurement only.
  - Simultaneous start/stop edges in IDLE → RUN entered.
- Abort/reset:
  - clr in RUN at count=37 → IDLE, count=0, cap_valid=0, previous cap_value retained.
  - rst_n low mid-RUN (asynchronous, between clk edges) → all outputs 0 immediately.
- Handshake hold: stay in HOLD for 30 cycles without cap_ack, with start_in pulsed in between → cap_valid and cap_value stable; after ack, IDLE with no pending measurement.

Source files
------------

// File: rtl/interval_capture_pkg.sv
// Shared definitions for the interval capture block.
// Holds the FSM state encoding and the default widths. The count width is
// shared with the loadable down counter so a captured interval can be fed
// back as its reload value.
package interval_capture_pkg;

    // Measurement FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ic_state_e;

    // Count/capture width, identical to the down counter's load/count path.
    localparam int IC_COUNT_WIDTH = 9;

    // Flip-flop stages per input synchronizer (never below 2).
    localparam int IC_SYNC_STAGES = 2;

endpackage

// File: rtl/interval_capture_if.sv
// Handshake/bus bundle of the interval capture block.
// master : drives start_in, stop_in, tick_en, clr, cap_ack;
//          observes count, cap_value, cap_valid, overflow, busy.
// slave  : the interval_capture block itself (the opposite directions).
interface interval_capture_if
    import interval_capture_pkg::*;
#(
    parameter int WIDTH = IC_COUNT_WIDTH
) ();

    logic             start_in;
    logic             stop_in;
    logic             tick_en;
    logic             clr;
    logic             cap_ack;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] cap_value;
    logic             cap_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output start_in, stop_in, tick_en, clr, cap_ack,
        input  count, cap_value, cap_valid, overflow, busy
    );

    modport slave (
        input  start_in, stop_in, tick_en, clr, cap_ack,
        output count, cap_value, cap_valid, overflow, busy
    );

endinterface

// File: rtl/interval_capture_edge_sync.sv
// edge_sync: synchronizes an asynchronous pin through SYNC_STAGES flops and
// produces a one-clock pulse on each rising edge of the synchronized level.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (clears all history flops)
//   d     - asynchronous input pin
//   pulse - single-cycle rising-edge pulse, SYNC_STAGES edges after the pin rises
// SYNC_STAGES must be at least 2.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer shift chain plus one flop of edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Decoded from flops only; registering it again would add a cycle of
    // pin-to-action latency.
    assign pulse = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/interval_capture.sv
// interval_capture: counts enabled clock ticks between a start event and a
// stop event and offers the result through a valid/ack handshake.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - interval_capture_if.slave:
//           start_in/stop_in (async pins, rising-edge), tick_en, clr, cap_ack,
//           count, cap_value, cap_valid, overflow, busy
// The count saturates at all-ones (overflow is then sticky until the next
// start or clr). clr beats every other event but leaves cap_value intact.
module interval_capture
    import interval_capture_pkg::*;
#(
    parameter int WIDTH       = IC_COUNT_WIDTH,
    parameter int SYNC_STAGES = IC_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    interval_capture_if.slave   bus
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             start_p_s;
    logic             stop_p_s;
    ic_state_e        state_r;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] cap_value_r;
    logic             cap_valid_r;
    logic             overflow_r;
    logic             busy_r;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.start_in),
        .pulse (start_p_s)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.stop_in),
        .pulse (stop_p_s)
    );

    // Measurement FSM, saturating counter and capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            cap_value_r <= '0;
            cap_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else if (bus.clr) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            cap_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A stop edge in the same cycle is simply dropped.
                    if (start_p_s) begin
                        count_r    <= '0;
                        overflow_r <= 1'b0;
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Stop captures the pre-increment value; no tick that cycle.
                    if (stop_p_s) begin
                        cap_value_r <= count_r;
                        cap_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                        busy_r      <= 1'b0;
                    end else if (bus.tick_en) begin
                        if (count_r == COUNT_MAX) begin
                            overflow_r <= 1'b1;
                        end else begin
                            count_r <= count_r + COUNT_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    // Start edges arriving here are lost, not queued.
                    if (bus.cap_ack) begin
                        cap_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cap_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count     = count_r;
    assign bus.cap_value = cap_value_r;
    assign bus.cap_valid = cap_valid_r;
    assign bus.overflow  = overflow_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_interval_capture.sv
// Self-checking bench for interval_capture: a hand-derived vector table,
// directed multi-cycle sequences and randomized stimulus against a
// behavioural model that treats each synchronizer as a pin-history delay.
module tb_interval_capture;
    import interval_capture_pkg::*;

    localparam int W    = IC_COUNT_WIDTH;
    localparam int S    = IC_SYNC_STAGES;
    localparam int MAXV = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    interval_capture_if #(.WIDTH(W)) bus ();

    interval_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: 0 = idle, 1 = measuring, 2 = holding a result.
    int m_state;
    int m_count;
    int m_cap;
    int m_cv;
    int m_ov;
    bit st_hist[$];
    bit sp_hist[$];

    typedef struct {
        bit st, sp, tk, cl, ak;
        int e_busy, e_cv, e_count, e_cap, e_ov;
    } vec_t;
    vec_t tbl[11];

    function automatic void check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_count = 0; m_cap = 0; m_cv = 0; m_ov = 0;
        st_hist.delete();
        sp_hist.delete();
        for (int i = 0; i < S + 1; i++) begin
            st_hist.push_back(1'b0);
            sp_hist.push_back(1'b0);
        end
    endfunction

    // One clock edge: a pin sampled at edge n-S (high) after n-S-1 (low) acts now.
    function automatic void model_edge(bit st, bit sp, bit tk, bit cl, bit ak);
        bit start_ev = st_hist[S-1] && !st_hist[S];
        bit stop_ev  = sp_hist[S-1] && !sp_hist[S];
        st_hist.push_front(st); void'(st_hist.pop_back());
        sp_hist.push_front(sp); void'(sp_hist.pop_back());
        if (cl) begin
            m_state = 0; m_count = 0; m_cv = 0; m_ov = 0;
        end else if (m_state == 0) begin
            if (start_ev) begin m_state = 1; m_count = 0; m_ov = 0; end
        end else if (m_state == 1) begin
            if (stop_ev) begin m_cap = m_count; m_cv = 1; m_state = 2; end
            else if (tk) begin
                if (m_count == MAXV) m_ov = 1;
                else m_count = m_count + 1;
            end
        end else begin
            if (ak) begin m_cv = 0; m_state = 0; end
        end
    endfunction

    function automatic void compare_all(string tag);
        check({tag, "_busy"},      int'(bus.busy),      int'(m_state == 1));
        check({tag, "_cap_valid"}, int'(bus.cap_valid), m_cv);
        check({tag, "_count"},     int'(bus.count),     m_count);
        check({tag, "_cap_value"}, int'(bus.cap_value), m_cap);
        check({tag, "_overflow"},  int'(bus.overflow),  m_ov);
    endfunction

    task automatic set_in(bit st, bit sp, bit tk, bit cl, bit ak);
        bus.start_in = st; bus.stop_in = sp; bus.tick_en = tk;
        bus.clr = cl; bus.cap_ack = ak;
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        if (rst_n) model_edge(bus.start_in, bus.stop_in, bus.tick_en, bus.clr, bus.cap_ack);
        else model_reset();
        @(negedge clk);
        compare_all(tag);
    endtask

    // sel 0 waits on busy, sel 1 on cap_valid; an expired budget is a failure.
    task automatic wait_for(int sel, bit val, int budget, string nm);
        int n = 0;
        while (((sel == 0) ? bus.busy : bus.cap_valid) != val && n < budget) begin
            tick(nm);
            n++;
        end
        if (((sel == 0) ? bus.busy : bus.cap_valid) != val)
            check({nm, "_timeout"}, n, -1);
    endtask

    task automatic pulse_pin(bit is_stop, bit tk, string nm);
        set_in(!is_stop, is_stop, tk, 1'b0, 1'b0);
        tick(nm);
        set_in(1'b0, 1'b0, tk, 1'b0, 1'b0);
    endtask

    task automatic ack_result(string nm);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(nm);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check({nm, "_valid_low"}, int'(bus.cap_valid), 0);
        check({nm, "_idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        int hold_cap;
        model_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // start, stop, tick, clr, ack | busy, cap_valid, count, cap_value, overflow
        tbl[0]  = '{1,0,1,0,0, 0,0,0,0,0};
        tbl[1]  = '{1,0,1,0,0, 0,0,0,0,0};
        tbl[2]  = '{0,0,1,0,0, 1,0,0,0,0};
        tbl[3]  = '{0,0,1,0,0, 1,0,1,0,0};
        tbl[4]  = '{0,0,0,0,0, 1,0,1,0,0};
        tbl[5]  = '{0,1,1,0,0, 1,0,2,0,0};
        tbl[6]  = '{0,0,1,0,0, 1,0,3,0,0};
        tbl[7]  = '{0,0,1,0,0, 0,1,3,3,0};
        tbl[8]  = '{0,0,1,0,0, 0,1,3,3,0};
        tbl[9]  = '{0,0,1,0,1, 0,0,3,3,0};
        tbl[10] = '{0,0,1,1,0, 0,0,0,3,0};

        // Reset state.
        repeat (2) tick("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one clock edge per row.
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].st, tbl[i].sp, tbl[i].tk, tbl[i].cl, tbl[i].ak);
            @(posedge clk);
            model_edge(bus.start_in, bus.stop_in, bus.tick_en, bus.clr, bus.cap_ack);
            @(negedge clk);
            check($sformatf("tbl%0d_busy", i),  int'(bus.busy),      tbl[i].e_busy);
            check($sformatf("tbl%0d_cv", i),    int'(bus.cap_valid), tbl[i].e_cv);
            check($sformatf("tbl%0d_count", i), int'(bus.count),     tbl[i].e_count);
            check($sformatf("tbl%0d_cap", i),   int'(bus.cap_value), tbl[i].e_cap);
            check($sformatf("tbl%0d_ov", i),    int'(bus.overflow),  tbl[i].e_ov);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("tbl_tail");

        // Basic capture: stop pin raised 5 cycles after RUN entry.
        pulse_pin(1'b0, 1'b1, "basic");
        wait_for(0, 1'b1, 10, "basic_run");
        repeat (5) tick("basic");
        pulse_pin(1'b1, 1'b1, "basic");
        wait_for(1, 1'b1, 10, "basic_hold");
        check("basic_cap_value", int'(bus.cap_value), 5 + S);
        check("basic_overflow", int'(bus.overflow), 0);
        ack_result("basic_ack");

        // Gated ticks: 20 cycles alternating tick_en gives 10 counts.
        pulse_pin(1'b0, 1'b0, "gated");
        wait_for(0, 1'b1, 10, "gated_run");
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 1'b0, (i % 2) == 0, 1'b0, 1'b0);
            tick("gated");
        end
        pulse_pin(1'b1, 1'b0, "gated");
        wait_for(1, 1'b1, 10, "gated_hold");
        check("gated_cap_value", int'(bus.cap_value), 10);
        ack_result("gated_ack");

        // Saturation.
        pulse_pin(1'b0, 1'b1, "sat");
        wait_for(0, 1'b1, 10, "sat_run");
        bus.tick_en = 1'b1;
        repeat (600) tick("sat");
        check("sat_count", int'(bus.count), MAXV);
        check("sat_overflow", int'(bus.overflow), 1);
        pulse_pin(1'b1, 1'b1, "sat");
        wait_for(1, 1'b1, 10, "sat_hold");
        check("sat_cap_value", int'(bus.cap_value), MAXV);
        ack_result("sat_ack");

        // Restart attempt in RUN is ignored, then clr at count 37.
        pulse_pin(1'b0, 1'b1, "rerun");
        wait_for(0, 1'b1, 10, "rerun_run");
        repeat (10) tick("rerun");
        pulse_pin(1'b0, 1'b1, "rerun");
        repeat (4) tick("rerun");
        check("rerun_count", int'(bus.count), 15);
        repeat (22) tick("rerun");
        check("clr_pre_count", int'(bus.count), 37);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("clr");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_count", int'(bus.count), 0);
        check("clr_busy", int'(bus.busy), 0);
        check("clr_cap_value", int'(bus.cap_value), MAXV);

        // Stop in IDLE does nothing.
        pulse_pin(1'b1, 1'b1, "idlestop");
        repeat (S + 3) tick("idlestop");
        check("idlestop_busy", int'(bus.busy), 0);
        check("idlestop_cv", int'(bus.cap_valid), 0);

        // Start held high for 50 cycles yields exactly one measurement.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (50) tick("held");
        bus.start_in = 1'b0;
        check("held_busy", int'(bus.busy), 1);
        pulse_pin(1'b1, 1'b1, "held");
        wait_for(1, 1'b1, 10, "held_hold");
        ack_result("held_ack");
        repeat (10) tick("held_after");
        check("held_after_busy", int'(bus.busy), 0);

        // Simultaneous start and stop edges in IDLE: start wins.
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick("simul");
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (S) tick("simul");
        check("simul_busy", int'(bus.busy), 1);
        repeat (3) tick("simul");
        check("simul_still_run", int'(bus.busy), 1);

        // HOLD for 30 cycles with a start pulse that must be lost.
        pulse_pin(1'b1, 1'b1, "hold");
        wait_for(1, 1'b1, 10, "hold_enter");
        hold_cap = m_cap;
        for (int i = 0; i < 30; i++) begin
            set_in(i == 10, 1'b0, 1'b1, 1'b0, 1'b0);
            tick("hold");
        end
        check("hold_cv", int'(bus.cap_valid), 1);
        check("hold_cap_value", int'(bus.cap_value), hold_cap);
        ack_result("hold_ack");
        repeat (8) tick("hold_after");
        check("hold_after_busy", int'(bus.busy), 0);

        // Asynchronous reset between edges in the middle of a measurement.
        pulse_pin(1'b0, 1'b1, "arst");
        wait_for(0, 1'b1, 10, "arst_run");
        repeat (10) tick("arst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("arst_now");
        check("arst_count", int'(bus.count), 0);
        repeat (2) tick("arst_low");
        rst_n = 1'b1;
        repeat (2) tick("arst_rel");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(3) == 0, $urandom_range(4) == 0,
                   $urandom_range(3) != 0, $urandom_range(99) == 0,
                   $urandom_range(5) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
